// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite types and helpers for the SRAM slave: transfer enums,
// slave FSM states, alignment check and byte-strobe decode.
package ahb_sram_slave_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } transfer_size;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } transfer_kind;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_t;

  // Sizes wider than a word are never aligned, so they fall into the error path.
  function automatic logic size_aligned(transfer_size size, logic [1:0] lo);
    case (size)
      SIZE_BYTE: size_aligned = 1'b1;
      SIZE_HALF: size_aligned = ~lo[0];
      SIZE_WORD: size_aligned = (lo == 2'b00);
      default:   size_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(transfer_size size, logic [1:0] lo);
    case (size)
      SIZE_BYTE: byte_strobe = 4'b0001 << lo;
      SIZE_HALF: byte_strobe = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: byte_strobe = 4'b1111;
      default:   byte_strobe = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite per-device slot between the bus controller (master side) and the SRAM slave.
// Handshake: a transfer is accepted at a rising edge when sel && ready_in && trans is
// NONSEQ/SEQ; its data phase completes on the first edge where ready_out is high.
interface ahb_sram_slave_if;
  import ahb_sram_slave_pkg::*;

  logic             sel;
  logic [31:0]      addr;
  logic             write;
  transfer_size     size;
  transfer_kind     trans;
  logic             ready_in;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             ready_out;
  transfer_response resp;

  modport slave (
    input  sel, addr, write, size, trans, ready_in, wdata,
    output rdata, ready_out, resp
  );

  modport master (
    output sel, addr, write, size, trans, ready_in, wdata,
    input  rdata, ready_out, resp
  );

endinterface

// File: rtl/ahb_sram_array.sv
// Word-organised register array with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_array #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          clock,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: accept/legality check, wait-state counter and a
// two-cycle ERROR response, in front of a byte-writable word array.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 512,
  parameter int          WAIT_STATES = 0
) (
  input  logic                clock,
  input  logic                reset,
  ahb_sram_slave_if.slave     bus,
  output slave_state_t        dbg_state
);

  localparam int          AW           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] REGION_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_STATES);

  slave_state_t     state;
  logic             ready_q;
  transfer_response resp_q;
  logic [3:0]       wait_cnt;
  logic [AW-1:0]    dp_word;
  logic             dp_write;
  transfer_size     dp_size;
  logic [1:0]       dp_lo;

  logic [31:0] offset;
  logic        accept;
  logic        legal;
  logic [3:0]  we;
  logic [31:0] arr_rdata;

  assign offset = bus.addr - BASE_ADDR;
  assign accept = bus.sel && bus.ready_in &&
                  (bus.trans == TRANS_NONSEQ || bus.trans == TRANS_SEQ);
  assign legal  = (bus.size <= SIZE_WORD) &&
                  size_aligned(bus.size, bus.addr[1:0]) &&
                  ({1'b0, offset} < REGION_BYTES);

  // New accepts are only taken when no data phase is stalling the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      resp_q   <= RESP_OKAY;
      wait_cnt <= 4'd0;
      dp_word  <= '0;
      dp_write <= 1'b0;
      dp_size  <= SIZE_BYTE;
      dp_lo    <= 2'b00;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state    <= ST_DATA;
            ready_q  <= 1'b1;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= RESP_ERROR;
        end
        default: begin
          if (accept) begin
            dp_word <= offset[AW+1:2];
            dp_size <= bus.size;
            dp_lo   <= bus.addr[1:0];
            if (!legal) begin
              state    <= ST_ERR1;
              ready_q  <= 1'b0;
              resp_q   <= RESP_ERROR;
              dp_write <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              ready_q  <= 1'b0;
              resp_q   <= RESP_OKAY;
              wait_cnt <= WAIT_INIT;
              dp_write <= bus.write;
            end else begin
              state    <= ST_DATA;
              ready_q  <= 1'b1;
              resp_q   <= RESP_OKAY;
              dp_write <= bus.write;
            end
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  // Write commits on the edge that ends DATA; a reset on that edge cancels it.
  assign we = (state == ST_DATA && dp_write && !reset) ? byte_strobe(dp_size, dp_lo) : 4'b0000;

  ahb_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock (clock),
    .we    (we),
    .addr  (dp_word),
    .wdata (bus.wdata),
    .rdata (arr_rdata)
  );

  assign bus.rdata     = (state == ST_DATA && !dp_write) ? arr_rdata : 32'h0;
  assign bus.ready_out = ready_q;
  assign bus.resp      = resp_q;
  assign dbg_state     = state;

endmodule
